// File: rtl/count_step_pkg.sv
// rtl/count_step_pkg.sv - shared states, direction/BCD constants and BCD step arithmetic for count_step_ctrl
package count_step_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } state_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;
    localparam logic [3:0] BCD_DIGIT_MIN = 4'd0;

    // Timer must span the longer of the two intervals.
    function automatic int timer_width(input int hold_cycles, input int repeat_cycles);
        return $clog2((hold_cycles > repeat_cycles) ? hold_cycles : repeat_cycles);
    endfunction

    // One BCD step of a two-digit count {tens, ones}, wrapping between 00 and max_bcd.
    // The current value is assumed valid (<= max_bcd, digits 0..9).
    function automatic logic [7:0] bcd_step(input logic [7:0] cur, input logic up,
                                            input logic [7:0] max_bcd);
        logic [3:0] tens;
        logic [3:0] ones;
        tens = cur[7:4];
        ones = cur[3:0];
        if (up == DIR_UP) begin
            if (cur == max_bcd) begin
                tens = BCD_DIGIT_MIN;
                ones = BCD_DIGIT_MIN;
            end else if (ones == BCD_DIGIT_MAX) begin
                tens = tens + 4'd1;
                ones = BCD_DIGIT_MIN;
            end else begin
                ones = ones + 4'd1;
            end
        end else begin
            if (cur == 8'h00) begin
                tens = max_bcd[7:4];
                ones = max_bcd[3:0];
            end else if (ones == BCD_DIGIT_MIN) begin
                tens = tens - 4'd1;
                ones = BCD_DIGIT_MAX;
            end else begin
                ones = ones - 4'd1;
            end
        end
        return {tens, ones};
    endfunction

endpackage

// File: rtl/hold_repeat_timer.sv
// rtl/hold_repeat_timer.sv - shared hold/auto-repeat interval timer for count_step_ctrl
module hold_repeat_timer
    import count_step_pkg::*;
#(
    parameter int HOLD_CYCLES   = 12_500_000,
    parameter int REPEAT_CYCLES = 2_500_000
) (
    input  logic i_Clk,
    input  logic i_Reset,
    input  logic i_Clear,
    input  logic i_Run,
    output logic o_Hold_Done,
    output logic o_Repeat_Tick
);

    localparam int TIMER_W = timer_width(HOLD_CYCLES, REPEAT_CYCLES);
    localparam logic [TIMER_W-1:0] HOLD_LAST   = TIMER_W'(HOLD_CYCLES - 1);
    localparam logic [TIMER_W-1:0] REPEAT_LAST = TIMER_W'(REPEAT_CYCLES - 1);

    logic [TIMER_W-1:0] r_Timer;

    // Count cycles while running; clear has priority so the controller can restart an interval.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            r_Timer <= '0;
        end else if (i_Clear) begin
            r_Timer <= '0;
        end else if (i_Run) begin
            r_Timer <= r_Timer + TIMER_W'(1);
        end
    end

    assign o_Hold_Done   = (r_Timer == HOLD_LAST);
    assign o_Repeat_Tick = (r_Timer == REPEAT_LAST);

endmodule

// File: rtl/count_step_ctrl.sv
// rtl/count_step_ctrl.sv - up/down button step controller owning the BCD count; auto-repeat under COUNT_STEP_AUTO_REPEAT_EN
module count_step_ctrl
    import count_step_pkg::*;
#(
    parameter int HOLD_CYCLES   = 12_500_000,
    parameter int REPEAT_CYCLES = 2_500_000,
    parameter int MAX_COUNT     = 99
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic       i_Switch_Up,
    input  logic       i_Switch_Down,
    output logic [3:0] o_Digit_Ones,
    output logic [3:0] o_Digit_Tens,
    output logic       o_Step,
    output logic       o_Dir
);

    localparam logic [7:0] MAX_BCD = {4'(MAX_COUNT / 10), 4'(MAX_COUNT % 10)};

    if (HOLD_CYCLES < 2 || REPEAT_CYCLES < 1 || MAX_COUNT < 1 || MAX_COUNT > 99) begin : g_bad_params
        $error("count_step_ctrl: parameter out of range");
    end

    state_t     r_State;
    logic       r_Active;
    logic       r_Up_Prev;
    logic       r_Down_Prev;
    logic [7:0] r_Count;

    logic up_press;
    logic down_press;
    logic active_level;

    assign up_press     = i_Switch_Up & ~r_Up_Prev;
    assign down_press   = i_Switch_Down & ~r_Down_Prev;
    assign active_level = (r_Active == DIR_UP) ? i_Switch_Up : i_Switch_Down;

`ifdef COUNT_STEP_AUTO_REPEAT_EN
    logic timer_run;
    logic timer_clear;
    logic hold_done;
    logic repeat_tick;

    // Timer runs only while the latched button is held; it restarts at each hold/repeat step.
    assign timer_run   = (r_State != IDLE) && active_level;
    assign timer_clear = !timer_run
                       || ((r_State == HOLD) && hold_done)
                       || ((r_State == REPEAT) && repeat_tick);

    hold_repeat_timer #(
        .HOLD_CYCLES   (HOLD_CYCLES),
        .REPEAT_CYCLES (REPEAT_CYCLES)
    ) u_timer (
        .i_Clk         (i_Clk),
        .i_Reset       (i_Reset),
        .i_Clear       (timer_clear),
        .i_Run         (timer_run),
        .o_Hold_Done   (hold_done),
        .o_Repeat_Tick (repeat_tick)
    );
`endif

    // Press arbitration, hold/repeat sequencing and count update with registered step/dir outputs.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            r_State     <= IDLE;
            r_Active    <= DIR_UP;
            r_Up_Prev   <= 1'b0;
            r_Down_Prev <= 1'b0;
            r_Count     <= 8'h00;
            o_Step      <= 1'b0;
            o_Dir       <= DIR_UP;
        end else begin
            r_Up_Prev   <= i_Switch_Up;
            r_Down_Prev <= i_Switch_Down;
            o_Step      <= 1'b0;
            case (r_State)
                IDLE: begin
                    if (up_press) begin
                        r_Count  <= bcd_step(r_Count, DIR_UP, MAX_BCD);
                        o_Step   <= 1'b1;
                        o_Dir    <= DIR_UP;
                        r_Active <= DIR_UP;
                        r_State  <= HOLD;
                    end else if (down_press) begin
                        r_Count  <= bcd_step(r_Count, DIR_DOWN, MAX_BCD);
                        o_Step   <= 1'b1;
                        o_Dir    <= DIR_DOWN;
                        r_Active <= DIR_DOWN;
                        r_State  <= HOLD;
                    end
                end
                HOLD: begin
                    if (!active_level) begin
                        r_State <= IDLE;
                    end
`ifdef COUNT_STEP_AUTO_REPEAT_EN
                    else if (hold_done) begin
                        r_Count <= bcd_step(r_Count, r_Active, MAX_BCD);
                        o_Step  <= 1'b1;
                        o_Dir   <= r_Active;
                        r_State <= REPEAT;
                    end
`endif
                end
                REPEAT: begin
                    if (!active_level) begin
                        r_State <= IDLE;
                    end
`ifdef COUNT_STEP_AUTO_REPEAT_EN
                    else if (repeat_tick) begin
                        r_Count <= bcd_step(r_Count, r_Active, MAX_BCD);
                        o_Step  <= 1'b1;
                        o_Dir   <= r_Active;
                    end
`endif
                end
                default: begin
                    r_State <= IDLE;
                end
            endcase
        end
    end

    assign o_Digit_Tens = r_Count[7:4];
    assign o_Digit_Ones = r_Count[3:0];

endmodule
